// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and edge-detects the two raw
// push-buttons of the PWM duty-control path. It emits one-cycle b_up / b_down
// pulses, so one physical press steps the duty-level counter by exactly one.
// Channel index 0 is the up button and index 1 is the down button.
// Optional feature macro: BUTTON_AUTOREPEAT_EN. When it is defined, each
// channel gets an IDLE -> DELAY -> REPEAT auto-repeat FSM. The per-channel
// state is visible as g_chan[ch].state.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES      = 250000,
    parameter int unsigned REPEAT_DELAY_CYCLES  = 25000000,
    parameter int unsigned REPEAT_PERIOD_CYCLES = 5000000,
    parameter int unsigned CNT_W                = 25
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic b_up,
    output logic b_down,
    output logic up_level,
    output logic down_level
);

    // Last count value before the debounced level flips.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Catch impossible configurations at elaboration: every counter must hold
    // its terminal value, and debounce needs at least two cycles.
    if ((DEBOUNCE_CYCLES < 2) ||
        (64'(DEBOUNCE_CYCLES)      > (64'd1 << CNT_W)) ||
        (64'(REPEAT_DELAY_CYCLES)  > (64'd1 << CNT_W)) ||
        (64'(REPEAT_PERIOD_CYCLES) > (64'd1 << CNT_W))) begin : g_cfg_error
        $error("button_conditioner: cycle parameters do not fit CNT_W or DEBOUNCE_CYCLES < 2");
    end

`ifdef BUTTON_AUTOREPEAT_EN
    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD_CYCLES - 1);
`endif

    logic [1:0] raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] stable;
    logic [1:0] stable_d;
    logic [1:0] press;
    logic [1:0] fire;

    assign raw = {btn_down_raw, btn_up_raw};

    // Two-flop synchroniser for both raw buttons.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Previous debounced levels, used for rising-edge (press) detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stable_d <= 2'b00;
        end else begin
            stable_d <= stable;
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic             stab;
        logic [CNT_W-1:0] cnt;

        // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive
        // disagreeing samples. Any agreement restarts the count.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                stab <= 1'b0;
                cnt  <= '0;
            end else if (sync2[ch] == stab) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                stab <= ~stab;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign stable[ch] = stab;

        // A press counts only while the other channel is not held.
        assign press[ch] = stab & ~stable_d[ch] & ~stable[1-ch];

`ifdef BUTTON_AUTOREPEAT_EN
        rpt_state_t       state;
        rpt_state_t       state_nxt;
        logic [CNT_W-1:0] rcnt;
        logic             rcnt_clr;
        logic             rep_fire;
        logic             held_alone;

        assign held_alone = stab & ~stable[1-ch];

        // Auto-repeat state register and repeat counter.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                state <= RPT_IDLE;
                rcnt  <= '0;
            end else begin
                state <= state_nxt;
                rcnt  <= rcnt_clr ? '0 : rcnt + 1'b1;
            end
        end

        // Auto-repeat next state: a release or a held other channel aborts.
        always_comb begin
            state_nxt = state;
            case (state)
                RPT_IDLE:   if (press[ch]) state_nxt = RPT_DELAY;
                RPT_DELAY:  if (!held_alone) state_nxt = RPT_IDLE;
                            else if (rcnt == DLY_LAST) state_nxt = RPT_REPEAT;
                RPT_REPEAT: if (!held_alone) state_nxt = RPT_IDLE;
                default:    state_nxt = RPT_IDLE;
            endcase
        end

        // Auto-repeat outputs: fire at the terminal count and restart counting.
        always_comb begin
            rep_fire = 1'b0;
            rcnt_clr = 1'b1;
            case (state)
                RPT_DELAY: if (held_alone) begin
                    rep_fire = (rcnt == DLY_LAST);
                    rcnt_clr = (rcnt == DLY_LAST);
                end
                RPT_REPEAT: if (held_alone) begin
                    rep_fire = (rcnt == PER_LAST);
                    rcnt_clr = (rcnt == PER_LAST);
                end
                default: begin
                    rep_fire = 1'b0;
                    rcnt_clr = 1'b1;
                end
            endcase
        end

        assign fire[ch] = press[ch] | rep_fire;
`else
        assign fire[ch] = press[ch];
`endif
    end

    // Registered one-cycle output pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            b_up   <= 1'b0;
            b_down <= 1'b0;
        end else begin
            b_up   <= fire[0];
            b_down <= fire[1];
        end
    end

    assign up_level   = stable[0];
    assign down_level = stable[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY_CYCLES=20, REPEAT_PERIOD_CYCLES=8. Edge numbers count rising
// clock edges after a raw input change; outputs are sampled 1 ns after each edge.
module tb_button_conditioner;

    logic clock = 1'b0;
    logic reset_n;
    logic btn_up_raw;
    logic btn_down_raw;
    logic b_up;
    logic b_down;
    logic up_level;
    logic down_level;

    int n_vec  = 0;
    int n_miss = 0;

    // Scenario 5 hand-computed pulse edges: press at 7, then 7+20, then every 8.
    int rpt_edges [6] = '{7, 27, 35, 43, 51, 59};

    // Bounce pattern for the down button; high runs are at most 3 cycles long.
    logic bounce [30] = '{1,0,1,1,0,0,1,1,1,0,1,0,0,1,1,0,1,1,1,0,0,1,0,1,1,0,1,1,1,0};

    button_conditioner #(
        .DEBOUNCE_CYCLES     (4),
        .REPEAT_DELAY_CYCLES (20),
        .REPEAT_PERIOD_CYCLES(8),
        .CNT_W               (8)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .btn_up_raw  (btn_up_raw),
        .btn_down_raw(btn_down_raw),
        .b_up        (b_up),
        .b_down      (b_down),
        .up_level    (up_level),
        .down_level  (down_level)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic eu, input logic ed,
                           input logic elu, input logic eld);
        chk({tag, " b_up"},       b_up,       eu);
        chk({tag, " b_down"},     b_down,     ed);
        chk({tag, " up_level"},   up_level,   elu);
        chk({tag, " down_level"}, down_level, eld);
    endtask

    task automatic do_reset();
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b0;
        reset_n      = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int at_edge;
        logic exp_p;

        // Reset state.
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b0;
        reset_n      = 1'b0;
        #2;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        reset_n = 1'b1;

        // 1: clean up press held 40 cycles.
        btn_up_raw = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            chk_all($sformatf("s1 e%0d", e), e == 7, 1'b0, e >= 6, 1'b0);
        end
        do_reset();

        // 2: bouncing down button, then a steady press.
        for (int i = 0; i < 30; i++) begin
            btn_down_raw = bounce[i];
            tick();
            chk_all($sformatf("s2 bounce%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        btn_down_raw = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            chk_all($sformatf("s2 e%0d", e), 1'b0, e == 7, 1'b0, e >= 6);
        end
        do_reset();

        // 3: simultaneous press; levels rise together, no pulses.
        btn_up_raw   = 1'b1;
        btn_down_raw = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            chk_all($sformatf("s3 e%0d", e), 1'b0, 1'b0, e >= 6, e >= 6);
        end
        do_reset();

        // 4: reset while up is held, at edge 5 and again mid-pulse at edge 7.
        for (int k = 0; k < 2; k++) begin
            at_edge = (k == 0) ? 5 : 7;
            btn_up_raw = 1'b1;
            for (int e = 1; e <= at_edge; e++) begin
                tick();
                chk_all($sformatf("s4.%0d pre e%0d", k, e), e == 7, 1'b0, e >= 6, 1'b0);
            end
            reset_n = 1'b0;
            #1;
            chk_all($sformatf("s4.%0d async", k), 1'b0, 1'b0, 1'b0, 1'b0);
            for (int e = 1; e <= 3; e++) begin
                tick();
                chk_all($sformatf("s4.%0d in-reset e%0d", k, e), 1'b0, 1'b0, 1'b0, 1'b0);
            end
            reset_n = 1'b1;
            for (int e = 1; e <= 12; e++) begin
                tick();
                chk_all($sformatf("s4.%0d post e%0d", k, e), e == 7, 1'b0, e >= 6, 1'b0);
            end
            do_reset();
        end

        // 5/6: up held 60 cycles, then released; debounced release at edge 66.
        btn_up_raw = 1'b1;
        for (int e = 1; e <= 90; e++) begin
            if (e == 61) btn_up_raw = 1'b0;
            tick();
`ifdef BUTTON_AUTOREPEAT_EN
            exp_p = 1'b0;
            foreach (rpt_edges[j]) if (rpt_edges[j] == e) exp_p = 1'b1;
`else
            exp_p = (e == 7);
`endif
            chk_all($sformatf("s5 e%0d", e), exp_p, 1'b0, (e >= 6) && (e < 66), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

- Conditions the two raw push-buttons of the PWM duty-control path: synchronise, debounce, edge-detect.
- Outputs single-cycle `b_up` / `b_down` pulses that drive the `B_UP` / `B_DOWN` inputs of the 0–10 duty-level up/down counter, so one physical press steps the level by exactly one.
- Sits between the board button pins and that counter, in the same `clock` domain.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive cycles an input must differ from its stable level before the level flips (5 ms at 50 MHz). Minimum 2.
- `REPEAT_DELAY_CYCLES`, default 25000000: hold time before the first auto-repeat pulse (auto-repeat build only).
- `REPEAT_PERIOD_CYCLES`, default 5000000: interval between subsequent auto-repeat pulses (auto-repeat build only).
- `CNT_W`, default 25: counter width. Must hold the largest of the three cycle parameters.
- `clock`  in  1  system clock; all state on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset; clears all state immediately.
- `btn_up_raw`  in  1  raw up button, active-high, asynchronous to `clock`.
- `btn_down_raw`  in  1  raw down button, active-high, asynchronous to `clock`.
- `b_up`  out  1  registered one-cycle increment pulse; reset value 0.
- `b_down`  out  1  registered one-cycle decrement pulse; reset value 0.
- `up_level`  out  1  debounced level of the up button; reset value 0.
- `down_level`  out  1  debounced level of the down button; reset value 0.

## Operation
**Synchroniser.** Each raw input passes through a 2-flop synchroniser (reset to 0). `sync` is the second flop.

**Debounce (per channel).** Each channel holds a `stable` level and a counter `cnt`.
- If `sync == stable`, `cnt` is cleared to 0.
- If `sync != stable` and `cnt == DEBOUNCE_CYCLES-1`, `stable` toggles and `cnt` is cleared.
- Otherwise `cnt` increments. It never wraps, because it is cleared before reaching `DEBOUNCE_CYCLES`.

**Press detection.**
- A press is the rising edge of `stable`, i.e. the new value is 1 and the previous value was 0.
- Release, the falling edge of `stable`, produces no pulse.

**Mutual exclusion.**
- `b_up` is set on an up press only if the down channel's `stable` (post-update value) is 0. `b_down` is symmetric.
- If both channels press in the same cycle, neither pulse fires.
- `b_up` and `b_down` are never high together.

**Pulse width.** Each pulse is high for exactly one cycle per press, regardless of hold time, unless auto-repeat is compiled in.

**Reset.**
- Asserting `reset_n` mid-press drops all outputs to 0 asynchronously.
- A button held through reset deassertion counts as a fresh press: stable is 0 and sync goes to 1.

## Timing
- Cycle numbering: raw input changes before edge 1 and is held.
  - Sync output updates at edge 2.
  - `stable` flips at edge `DEBOUNCE_CYCLES+2`.
  - Pulse is high after edge `DEBOUNCE_CYCLES+3` for one cycle.
- Glitch rejection: any excursion shorter than `DEBOUNCE_CYCLES` cycles at the sync output is ignored, and `cnt` restarts from 0.
- Release takes the same `DEBOUNCE_CYCLES+2` edges to clear `*_level`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `BUTTON_AUTOREPEAT_EN`.
- **Defined:** each channel adds an FSM IDLE → DELAY → REPEAT.
  - A press pulse moves IDLE → DELAY and clears the repeat counter.
  - In DELAY, after `REPEAT_DELAY_CYCLES` cycles with the channel still held and the other channel not held: emit one pulse, enter REPEAT.
  - In REPEAT: emit one pulse every `REPEAT_PERIOD_CYCLES` cycles.
  - Debounced release, or the other channel becoming held, returns the FSM to IDLE with no further pulses.
  - Repeat pulses obey the same mutual-exclusion rule.
- **Undefined:** no FSM and no repeat counter logic; exactly one pulse per press. `REPEAT_*` parameters are ignored.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY_CYCLES=20`, `REPEAT_PERIOD_CYCLES=8`.

1. **Clean press.** `btn_up_raw` 0→1 before edge 1, held 40 cycles → `up_level`=1 after edge 6; `b_up`=1 only in the cycle after edge 7; `b_down` stays 0.
2. **Bounce.** `btn_down_raw` toggles with high runs of 1–3 cycles for 30 cycles, then held 1 → no `b_down` during bouncing; exactly one `b_down` pulse 7 edges after the final steady rise.
3. **Simultaneous press.** Both raws rise in the same cycle and are held → both levels go to 1 together; `b_up`=`b_down`=0 throughout.
4. **Reset mid-press.** Hold up; assert `reset_n`=0 at edge 5 for 3 cycles → outputs 0 immediately; after release, one `b_up` pulse at `DEBOUNCE_CYCLES+3` edges post-reset.
5. **Auto-repeat (macro defined).** Hold up for 60 cycles → first pulse at edge 7; repeat pulses at edges 27, 35, 43, 51, 59; none after the debounced release.
6. **Without macro.** Same stimulus as scenario 5 → exactly one `b_up` pulse, at edge 7.
